// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: data widths, opcode
// constants, the fetch state encoding and small address/decode helpers.
package instr_fetch_pkg;

    localparam int INSTR_W = 8;
    localparam int ADDR_W  = 8;

    // Opcode field values carried in instr[7:6].
    localparam logic [1:0] OP_ALU_REG = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_STORE   = 2'b10;
    localparam logic [1:0] OP_ALU_IMM = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_OUT   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    // Sequential fetch address; the adder width makes 8'hFF wrap to 8'h00.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

    // Opcode is the top two bits of the instruction byte.
    function automatic logic [1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 2];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundles the instruction-memory port, the decoder handshake and the
// redirect/halt controls of the fetch unit.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_rvalid;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr;
    logic [1:0]          opcode;
    logic [ADDR_W-1:0]   instr_pc;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                halt_req;
    logic                halted;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, halted,
        input  imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc, halt_req
    );

    // Memory / decoder / control side.
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, halted,
        output imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc, halt_req
    );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one memory request at a time, holds the
// returned byte for the decoder, and handles redirects and halt requests.
// A redirect while a response is still in flight parks the unit in DRAIN
// so the stale byte is swallowed rather than presented.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    fetch_state_e        state_r;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   fetch_pc_r;
    logic                imem_req_r;
    logic [ADDR_W-1:0]   imem_addr_r;
    logic                instr_valid_r;
    logic [INSTR_W-1:0]  instr_r;
    logic [ADDR_W-1:0]   instr_pc_r;
    logic                halted_r;

    assign bus.imem_req    = imem_req_r;
    assign bus.imem_addr   = imem_addr_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.instr       = instr_r;
    assign bus.opcode      = opcode_of(instr_r);
    assign bus.instr_pc    = instr_pc_r;
    assign bus.halted      = halted_r;

    // Fetch state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_PC;
            fetch_pc_r    <= {ADDR_W{1'b0}};
            imem_req_r    <= 1'b0;
            imem_addr_r   <= {ADDR_W{1'b0}};
            instr_valid_r <= 1'b0;
            instr_r       <= {INSTR_W{1'b0}};
            instr_pc_r    <= {ADDR_W{1'b0}};
            halted_r      <= 1'b0;
        end else begin
            // The request strobe is a single-cycle pulse.
            imem_req_r <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    if (bus.redirect_valid) begin
                        pc_r <= bus.redirect_pc;
                    end else if (bus.halt_req) begin
                        halted_r <= 1'b1;
                        state_r  <= ST_HALT;
                    end else begin
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= pc_r;
                        fetch_pc_r  <= pc_r;
                        pc_r        <= next_pc(pc_r);
                        state_r     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid && bus.redirect_valid) begin
                        // Response belongs to the abandoned path.
                        pc_r    <= bus.redirect_pc;
                        state_r <= ST_FETCH;
                    end else if (bus.imem_rvalid) begin
                        instr_r       <= bus.imem_rdata;
                        instr_pc_r    <= fetch_pc_r;
                        instr_valid_r <= 1'b1;
                        state_r       <= ST_OUT;
                    end else if (bus.redirect_valid) begin
                        pc_r    <= bus.redirect_pc;
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_OUT: begin
                    // Redirect wins over a same-cycle handshake.
                    if (bus.redirect_valid) begin
                        pc_r          <= bus.redirect_pc;
                        instr_valid_r <= 1'b0;
                        state_r       <= ST_FETCH;
                    end else if (instr_valid_r && bus.instr_ready) begin
                        instr_valid_r <= 1'b0;
                        state_r       <= ST_FETCH;
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                ST_DRAIN: begin
                    if (bus.redirect_valid) begin
                        pc_r <= bus.redirect_pc;
                    end else begin
                        pc_r <= pc_r;
                    end
                    // The in-flight response is dropped; fetch resumes afterwards.
                    if (bus.imem_rvalid) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_HALT: begin
                    if (bus.redirect_valid) begin
                        pc_r <= bus.redirect_pc;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (!bus.halt_req) begin
                        halted_r <= 1'b0;
                        state_r  <= ST_FETCH;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                default: begin
                    instr_valid_r <= 1'b0;
                    halted_r      <= 1'b0;
                    state_r       <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run checked against a program-order reference model.
module tb_instr_fetch;

    localparam logic [7:0] RESET_PC_TB = 8'h00;

    logic clk;
    logic rst;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RESET_PC_TB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    // Memory image and single-slot response model.
    logic [7:0] mem [256];
    int         mem_lat;
    bit         pend;
    logic [7:0] pend_addr;
    int         pend_cnt;

    // Events observed around the most recent clock edge.
    bit         acc_fire;
    logic [7:0] acc_instr;
    logic [1:0] acc_opc;
    logic [7:0] acc_pc;
    bit         redir_fire;
    logic [7:0] redir_pc_seen;
    bit         req_seen;
    logic [7:0] req_addr;

    // One clock: note what the edge will consume, advance, then model memory.
    task automatic tick();
        acc_fire      = (bus.instr_valid === 1'b1) && (bus.instr_ready === 1'b1) &&
                        (bus.redirect_valid === 1'b0) && (rst === 1'b0);
        acc_instr     = bus.instr;
        acc_opc       = bus.opcode;
        acc_pc        = bus.instr_pc;
        redir_fire    = (bus.redirect_valid === 1'b1) && (rst === 1'b0);
        redir_pc_seen = bus.redirect_pc;
        @(posedge clk);
        #1;
        bus.imem_rvalid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem[pend_addr];
                pend = 1'b0;
            end
        end
        req_seen = (bus.imem_req === 1'b1);
        req_addr = bus.imem_addr;
        if (req_seen) begin
            tests_run++;
            if (pend || bus.imem_rvalid) begin
                tests_failed++;
                $display("FAIL outstanding: new request at %h while one pending, required none", req_addr);
            end
            pend      = 1'b1;
            pend_addr = req_addr;
            pend_cnt  = mem_lat;
        end
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;
        bus.halt_req       = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 8'h00;
        pend               = 1'b0;
        mem_lat            = 1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Reset must win over every same-cycle input.
        rst                = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h77;
        bus.halt_req       = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.imem_rvalid    = 1'b1;
        bus.imem_rdata     = 8'hC3;
        pend               = 1'b0;
        mem_lat            = 1;
        tick();
        tests_run++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.opcode, bus.instr_pc, bus.halted} !== 29'd0) begin
            tests_failed++;
            $display("FAIL reset_state: req=%b addr=%h valid=%b instr=%h opc=%b pc=%h halted=%b, required all zero",
                     bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.opcode, bus.instr_pc, bus.halted);
        end
        bus.redirect_valid = 1'b0;
        bus.halt_req       = 1'b0;
        bus.instr_ready    = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC_TB) begin
            tests_failed++;
            $display("FAIL first_req: req=%b addr=%h, required 1 at %h", bus.imem_req, bus.imem_addr, RESET_PC_TB);
        end
    endtask

    task automatic test_basic();
        logic [7:0] req_q [$];
        logic [7:0] ins_q [$];
        logic [1:0] opc_q [$];
        logic [7:0] pc_q  [$];
        do_reset();
        mem[8'h00] = 8'h4A;
        mem[8'h01] = 8'h93;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 30 && ins_q.size() < 2; i++) begin
            tick();
            if (req_seen) req_q.push_back(req_addr);
            if (acc_fire) begin
                ins_q.push_back(acc_instr);
                opc_q.push_back(acc_opc);
                pc_q.push_back(acc_pc);
            end
        end
        bus.instr_ready = 1'b0;
        tests_run++;
        if (ins_q.size() < 2 || req_q.size() < 2) begin
            tests_failed++;
            $display("FAIL basic_timeout: got %0d instrs %0d reqs, required 2 and 2", ins_q.size(), req_q.size());
        end else begin
            tests_run++;
            if (req_q[0] !== 8'h00 || req_q[1] !== 8'h01) begin
                tests_failed++;
                $display("FAIL basic_addr: got %h,%h, required 00,01", req_q[0], req_q[1]);
            end
            tests_run++;
            if (ins_q[0] !== 8'h4A || opc_q[0] !== 2'b01 || pc_q[0] !== 8'h00) begin
                tests_failed++;
                $display("FAIL basic_first: got instr=%h opc=%b pc=%h, required 4a 01 00", ins_q[0], opc_q[0], pc_q[0]);
            end
            tests_run++;
            if (ins_q[1] !== 8'h93 || opc_q[1] !== 2'b10 || pc_q[1] !== 8'h01) begin
                tests_failed++;
                $display("FAIL basic_second: got instr=%h opc=%b pc=%h, required 93 10 01", ins_q[1], opc_q[1], pc_q[1]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_i;
        logic [7:0] s_instr;
        logic [1:0] s_opc;
        logic [7:0] s_pc;
        int         waited;
        do_reset();
        exp_i = 8'($urandom);
        mem[8'h00] = exp_i;
        waited = 0;
        while (bus.instr_valid !== 1'b1 && waited < 12) begin
            tick();
            waited++;
        end
        tests_run++;
        if (bus.instr_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_timeout: instr_valid=%b, required 1", bus.instr_valid);
        end
        s_instr = bus.instr;
        s_opc   = bus.opcode;
        s_pc    = bus.instr_pc;
        tests_run++;
        if (s_instr !== exp_i || s_opc !== exp_i[7:6] || s_pc !== 8'h00) begin
            tests_failed++;
            $display("FAIL stall_value: got %h/%b/%h, required %h/%b/00", s_instr, s_opc, s_pc, exp_i, exp_i[7:6]);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (bus.instr !== s_instr || bus.opcode !== s_opc || bus.instr_pc !== s_pc ||
                bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold: cycle %0d got %h/%b/%h v=%b req=%b, required %h/%b/%h v=1 req=0",
                         i, bus.instr, bus.opcode, bus.instr_pc, bus.instr_valid, bus.imem_req, s_instr, s_opc, s_pc);
            end
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        tests_run++;
        if (acc_fire !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_accept: acc=%b valid=%b req=%b, required 1 0 0", acc_fire, bus.instr_valid, bus.imem_req);
        end
        tick();
        tests_run++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) begin
            tests_failed++;
            $display("FAIL stall_next_req: req=%b addr=%h, required 1 at 01", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit         saw_ff;
        bit         got_req;
        bit         got_acc;
        logic [7:0] first_addr;
        logic [7:0] a_instr;
        logic [7:0] a_pc;
        do_reset();
        mem[8'h00] = 8'hFF;
        mem[8'h20] = 8'h5C;
        mem_lat    = 2;
        bus.instr_ready = 1'b1;
        tick();
        tests_run++;
        if (!req_seen || req_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL redir_first_req: req=%b addr=%h, required 1 at 00", req_seen, req_addr);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h20;
        tick();
        bus.redirect_valid = 1'b0;
        mem_lat = 1;
        saw_ff  = 1'b0;
        got_req = 1'b0;
        got_acc = 1'b0;
        first_addr = 8'h00;
        a_instr = 8'h00;
        a_pc    = 8'h00;
        for (int i = 0; i < 20 && !got_acc; i++) begin
            tick();
            if (bus.instr_valid === 1'b1 && bus.instr === 8'hFF) saw_ff = 1'b1;
            if (req_seen && !got_req) begin
                got_req    = 1'b1;
                first_addr = req_addr;
            end
            if (acc_fire) begin
                got_acc = 1'b1;
                a_instr = acc_instr;
                a_pc    = acc_pc;
            end
        end
        tests_run++;
        if (saw_ff) begin
            tests_failed++;
            $display("FAIL redir_drain: stale ff presented, required never");
        end
        tests_run++;
        if (!got_req || first_addr !== 8'h20) begin
            tests_failed++;
            $display("FAIL redir_addr: got req=%b addr=%h, required 1 at 20", got_req, first_addr);
        end
        tests_run++;
        if (!got_acc || a_instr !== 8'h5C || a_pc !== 8'h20) begin
            tests_failed++;
            $display("FAIL redir_instr: got acc=%b %h@%h, required 5c@20", got_acc, a_instr, a_pc);
        end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] req_q [$];
        logic [7:0] ins_q [$];
        logic [7:0] pc_q  [$];
        do_reset();
        mem[8'hFF] = 8'($urandom);
        mem[8'h00] = 8'($urandom);
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'hFF;
        tick();
        bus.redirect_valid = 1'b0;
        tests_run++;
        if (req_seen) begin
            tests_failed++;
            $display("FAIL wrap_suppress: req at %h during redirect, required none", req_addr);
        end
        for (int i = 0; i < 30 && ins_q.size() < 2; i++) begin
            tick();
            if (req_seen) req_q.push_back(req_addr);
            if (acc_fire) begin
                ins_q.push_back(acc_instr);
                pc_q.push_back(acc_pc);
            end
        end
        bus.instr_ready = 1'b0;
        tests_run++;
        if (ins_q.size() < 2 || req_q.size() < 2) begin
            tests_failed++;
            $display("FAIL wrap_timeout: got %0d instrs %0d reqs, required 2 and 2", ins_q.size(), req_q.size());
        end else begin
            tests_run++;
            if (req_q[0] !== 8'hFF || req_q[1] !== 8'h00) begin
                tests_failed++;
                $display("FAIL wrap_addr: got %h,%h, required ff,00", req_q[0], req_q[1]);
            end
            tests_run++;
            if (pc_q[0] !== 8'hFF || pc_q[1] !== 8'h00 || ins_q[0] !== mem[8'hFF] || ins_q[1] !== mem[8'h00]) begin
                tests_failed++;
                $display("FAIL wrap_instr: got %h@%h %h@%h, required %h@ff %h@00",
                         ins_q[0], pc_q[0], ins_q[1], pc_q[1], mem[8'hFF], mem[8'h00]);
            end
        end
    endtask

    task automatic test_halt();
        int  waited;
        bit  got_req;
        do_reset();
        mem[8'h00] = 8'($urandom);
        waited = 0;
        while (bus.instr_valid !== 1'b1 && waited < 12) begin
            tick();
            waited++;
        end
        bus.halt_req    = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        tests_run++;
        if (acc_fire !== 1'b1 || acc_instr !== mem[8'h00] || acc_pc !== 8'h00) begin
            tests_failed++;
            $display("FAIL halt_handoff: acc=%b %h@%h, required 1 %h@00", acc_fire, acc_instr, acc_pc, mem[8'h00]);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL halt_hold: cycle %0d halted=%b req=%b valid=%b, required 1 0 0",
                         i, bus.halted, bus.imem_req, bus.instr_valid);
            end
        end
        bus.halt_req = 1'b0;
        got_req = 1'b0;
        for (int i = 0; i < 5 && !got_req; i++) begin
            tick();
            if (req_seen) got_req = 1'b1;
        end
        tests_run++;
        if (!got_req || req_addr !== 8'h01 || bus.halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_resume: req=%b addr=%h halted=%b, required 1 at 01 halted 0", got_req, req_addr, bus.halted);
        end
    endtask

    task automatic test_reset_in_wait();
        bit got_acc;
        do_reset();
        mem[8'h00] = 8'($urandom);
        tick();
        tick();
        // Response strobe is being driven now; reset lands on the same edge.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstwait_clear: valid=%b req=%b, required 0 0", bus.instr_valid, bus.imem_req);
        end
        tick();
        tests_run++;
        if (!req_seen || req_addr !== RESET_PC_TB) begin
            tests_failed++;
            $display("FAIL rstwait_req: req=%b addr=%h, required 1 at %h", req_seen, req_addr, RESET_PC_TB);
        end
        bus.instr_ready = 1'b1;
        got_acc = 1'b0;
        for (int i = 0; i < 10 && !got_acc; i++) begin
            tick();
            if (acc_fire) got_acc = 1'b1;
        end
        bus.instr_ready = 1'b0;
        tests_run++;
        if (!got_acc || acc_pc !== RESET_PC_TB || acc_instr !== mem[RESET_PC_TB]) begin
            tests_failed++;
            $display("FAIL rstwait_instr: acc=%b %h@%h, required %h@%h", got_acc, acc_instr, acc_pc, mem[RESET_PC_TB], RESET_PC_TB);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_pc;
        bit         p_valid;
        logic [7:0] p_instr;
        logic [7:0] p_pc;
        int         n_acc;
        do_reset();
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        exp_pc = RESET_PC_TB;
        n_acc  = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 8'($urandom);
            end else begin
                bus.redirect_valid = 1'b0;
            end
            if (bus.halt_req) bus.halt_req = ($urandom_range(0, 7) != 0);
            else              bus.halt_req = ($urandom_range(0, 59) == 0);
            mem_lat = $urandom_range(1, 3);
            p_valid = (bus.instr_valid === 1'b1);
            p_instr = bus.instr;
            p_pc    = bus.instr_pc;
            tick();
            if (redir_fire) begin
                exp_pc = redir_pc_seen;
            end else if (acc_fire) begin
                n_acc++;
                tests_run++;
                if (acc_pc !== exp_pc || acc_instr !== mem[acc_pc]) begin
                    tests_failed++;
                    $display("FAIL rand_order: cycle %0d got %h@%h, required %h@%h", c, acc_instr, acc_pc, mem[exp_pc], exp_pc);
                end
                exp_pc = acc_pc + 8'd1;
            end
            if (p_valid && !acc_fire && !redir_fire) begin
                tests_run++;
                if (bus.instr_valid !== 1'b1 || bus.instr !== p_instr || bus.instr_pc !== p_pc) begin
                    tests_failed++;
                    $display("FAIL rand_stable: cycle %0d got v=%b %h@%h, required 1 %h@%h", c, bus.instr_valid, bus.instr, bus.instr_pc, p_instr, p_pc);
                end
            end
            if (bus.instr_valid === 1'b1) begin
                tests_run++;
                if (bus.opcode !== bus.instr[7:6]) begin
                    tests_failed++;
                    $display("FAIL rand_opcode: got %b, required %b", bus.opcode, bus.instr[7:6]);
                end
            end
            if (bus.halted === 1'b1) begin
                tests_run++;
                if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_halt: req=%b valid=%b, required 0 0", bus.imem_req, bus.instr_valid);
                end
            end
        end
        tests_run++;
        if (n_acc < 100) begin
            tests_failed++;
            $display("FAIL rand_progress: got %0d accepted, required at least 100", n_acc);
        end
        bus.redirect_valid = 1'b0;
        bus.halt_req       = 1'b0;
        bus.instr_ready    = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_wrap();
        test_halt();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 8'h00, address of the first fetch after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: imem_req  output  1  one-cycle pulse requesting an instruction at imem_addr.
REQ-005 Port: imem_addr  output  8  instruction memory address, valid while imem_req=1.
REQ-006 Port: imem_rvalid  input  1  memory response strobe, one cycle, at least 1 cycle after imem_req.
REQ-007 Port: imem_rdata  input  8  instruction byte, valid when imem_rvalid=1.
REQ-008 Port: instr_valid  output  1  held instruction available to the decoder.
REQ-009 Port: instr_ready  input  1  decoder accepts the instruction this cycle.
REQ-010 Port: instr  output  8  held instruction byte; opcode field is instr[7:6].
REQ-011 Port: opcode  output  2  equal to instr[7:6]; drives the decode stage's 2-bit opcode input.
REQ-012 Port: instr_pc  output  8  fetch address of the held instruction.
REQ-013 Port: redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-014 Port: redirect_pc  input  8  new fetch address.
REQ-015 Port: halt_req  input  1  level; stops new fetches while high.
REQ-016 Port: halted  output  1  high while the unit is in HALT.

Function
REQ-017 The block SHALL implement states FETCH, WAIT, OUT, DRAIN and HALT, with at most one memory request outstanding.
REQ-018 FETCH: if halt_req=1, go to HALT without a request; otherwise assert imem_req for 1 cycle with imem_addr=pc, latch fetch_pc=pc, set pc=pc+1 (mod 256, 8'hFF wraps to 8'h00), and go to WAIT.
REQ-019 WAIT: on imem_rvalid, capture imem_rdata into instr and fetch_pc into instr_pc, set instr_valid=1 on the next cycle, and go to OUT.
REQ-020 OUT: on instr_valid & instr_ready, clear instr_valid and go to FETCH; instr, opcode and instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-021 Throughput: an instruction is offered at most every 3 cycles with 1-cycle memory latency (FETCH, WAIT, OUT).
REQ-022 Redirect in FETCH or OUT: set pc=redirect_pc, clear instr_valid, suppress imem_req that cycle, and go to FETCH; redirect SHALL take priority over a same-cycle handshake, and that instruction counts as not accepted.
REQ-023 Redirect in WAIT without imem_rvalid: set pc=redirect_pc and go to DRAIN; DRAIN SHALL discard the next imem_rvalid and then go to FETCH.
REQ-024 Redirect in WAIT coinciding with imem_rvalid: discard the response, set pc=redirect_pc, and go to FETCH.
REQ-025 Redirect in DRAIN: update pc and remain in DRAIN.
REQ-026 Redirect in HALT: update pc and remain in HALT.
REQ-027 HALT: halted=1; when halt_req=0, go to FETCH; imem_req and instr_valid SHALL remain 0.
REQ-028 halt_req asserted in WAIT, OUT or DRAIN SHALL NOT abort the current instruction; it takes effect at the next FETCH.
REQ-029 imem_rvalid arriving in FETCH, OUT or HALT is a protocol error and SHALL be ignored.

Reset
REQ-030 On rst=1 at a clock edge: state=FETCH, pc=RESET_PC, imem_req=0, imem_addr=8'h00, instr_valid=0, instr=8'h00, instr_pc=8'h00, halted=0, and the drain flag cleared.
REQ-031 Reset SHALL override all inputs, including a same-cycle redirect, halt_req or imem_rvalid.
REQ-032 Reset during WAIT SHALL NOT produce a DRAIN; a late response after reset SHALL be ignored per REQ-029, or taken as the first fetch's response if it lands in WAIT.
REQ-033 The first imem_req SHALL occur in the first cycle after rst deasserts, unless halt_req=1.

Structure
REQ-034 A shared package SHALL hold the opcode constants (2'b00 ALU register, 2'b01 load, 2'b10 store, 2'b11 ALU immediate), the instruction width (8), the address width (8), and the fetch state encoding.
REQ-035 The block is a single module; no sub-module is required.

Verification
REQ-036 Reset, then memory returns 8'h4A, 8'h93 with 1-cycle latency and instr_ready=1 -> imem_addr 00 then 01; instr 4A with opcode 01 and instr_pc 00, then 93 with opcode 10 and instr_pc 01.
REQ-037 Hold instr_ready=0 for 5 cycles in OUT -> instr, opcode and instr_pc stable and no new imem_req; ready=1 -> next imem_req in the following cycle.
REQ-038 redirect_valid with redirect_pc=8'h20 during WAIT, response 8'hFF arrives 2 cycles later -> 8'hFF never presented; next imem_addr=20.
REQ-039 Start at pc=8'hFF -> fetch FF, then next imem_addr=00 (wrap).
REQ-040 halt_req=1 during OUT -> current instruction still handed off, then halted=1 and no imem_req; halt_req=0 -> FETCH resumes at the next sequential pc.
REQ-041 rst asserted in WAIT concurrent with imem_rvalid -> instr_valid=0, then first imem_req at RESET_PC.
